// File: rtl/event_encoder_pkg.sv
// Shared sizes, FSM state type and a decode helper for the event encoder.
package event_encoder_pkg;

  localparam int N_EV  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    OFFER = 1'b1
  } state_e;

  // One-hot decode of an event index (3-to-8).
  function automatic logic [N_EV-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [N_EV-1:0] one;
    one = {{(N_EV-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/event_encoder_prio_sel.sv
// Combinational priority selector: first set request bit scanning upward
// from start_i and wrapping modulo N_EV. start_i = 0 gives fixed
// lowest-index-wins priority.
module prio_sel
  import event_encoder_pkg::*;
(
  input  logic [N_EV-1:0]  req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [IDX_W-1:0] pos;

  // Scan from the far end back toward start_i so the nearest hit is written last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    for (int k = N_EV - 1; k >= 0; k--) begin
      pos = start_i + IDX_W'(k);
      if (req_i[pos]) begin
        idx_o   = pos;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_encoder.sv
// Event encoder: captures rising edges on eight request lines as pending
// events and offers them one at a time as a binary index with a
// valid/ready handshake. Fixed or round-robin priority by parameter.
module event_encoder
  import event_encoder_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_EV-1:0]  in,
  input  logic             clr,
  input  logic             ready,
  output logic [IDX_W-1:0] out,
  output logic             valid,
  output logic [N_EV-1:0]  pending,
  output logic             overflow
);

  logic [N_EV-1:0]  in_q;
  logic [N_EV-1:0]  pending_q;
  logic [N_EV-1:0]  pending_d;
  logic             overflow_q;
  logic             overflow_d;
  state_e           state_q;
  logic [IDX_W-1:0] out_q;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;

  logic [N_EV-1:0]  rise;
  logic [N_EV-1:0]  served;
  logic [N_EV-1:0]  cand;
  logic             hs;
  logic             load;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel;
  logic             found;

  assign rise = in & ~in_q;
  assign hs   = (state_q == OFFER) && ready;
  assign load = (state_q == EMPTY) || hs;

  // The served bit drops out of the candidate set; rises this edge are not
  // candidates yet, but they do re-set pending (set beats the handshake clear).
  assign served    = hs ? idx_onehot(out_q) : '0;
  assign cand      = pending_q & ~served;
  assign pending_d = cand | rise;

  // A rise on a bit that remains pending after this edge is a merged event.
  assign overflow_d = overflow_q | (|(rise & cand));

  // Round-robin scan begins just past the most recently served index,
  // including the one being served right now.
  assign last_d = hs ? out_q : last_q;
  assign start  = (ROUND_ROBIN != 0) ? (last_d + IDX_W'(1)) : '0;

  prio_sel u_prio_sel (
    .req_i   (cand),
    .start_i (start),
    .idx_o   (sel),
    .found_o (found)
  );

  // Edge-detect history, pending set, overflow flag and the EMPTY/OFFER FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q       <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      state_q    <= EMPTY;
      out_q      <= '0;
      last_q     <= '1;
    end else begin
      in_q <= in;
      if (clr) begin
        pending_q  <= '0;
        overflow_q <= 1'b0;
        state_q    <= EMPTY;
      end else begin
        pending_q  <= pending_d;
        overflow_q <= overflow_d;
        last_q     <= last_d;
        if (load) begin
          if (found) begin
            state_q <= OFFER;
            out_q   <= sel;
          end else begin
            state_q <= EMPTY;
          end
        end
      end
    end
  end

  assign out      = out_q;
  assign valid    = (state_q == OFFER);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_event_encoder.sv
// Self-checking bench for event_encoder: fixed-priority and round-robin
// instances share stimulus; both are compared against a behavioural model.
module tb_event_encoder;
  import event_encoder_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_r  = '0;
  logic       clr_r = 1'b0;
  logic       rdy_r = 1'b0;

  logic [2:0] out0, out1;
  logic       valid0, valid1;
  logic [7:0] pend0, pend1;
  logic       ovf0, ovf1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  event_encoder #(.ROUND_ROBIN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in_r), .clr(clr_r), .ready(rdy_r),
    .out(out0), .valid(valid0), .pending(pend0), .overflow(ovf0)
  );

  event_encoder #(.ROUND_ROBIN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in_r), .clr(clr_r), .ready(rdy_r),
    .out(out1), .valid(valid1), .pending(pend1), .overflow(ovf1)
  );

  // Behavioural model state: a set of pending indices plus the current offer.
  typedef struct {
    logic [7:0] pend;
    bit         valid;
    int         out;
    bit         ovf;
    logic [7:0] prev;
    int         last;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_reset();
    model_t m;
    m.pend = '0; m.valid = 0; m.out = 0; m.ovf = 0; m.prev = '0; m.last = 7;
    return m;
  endfunction

  function automatic model_t step(model_t m, int rr, logic [7:0] in_v, bit clr_v, bit rdy_v);
    model_t     n;
    bit         hs;
    logic [7:0] rise;
    logic [7:0] cand;
    int         pick;
    int         idx;
    n    = m;
    hs   = m.valid && rdy_v;
    rise = in_v & ~m.prev;
    n.prev = in_v;
    if (clr_v) begin
      n.pend = '0; n.valid = 0; n.ovf = 0;
      return n;
    end
    cand = m.pend;
    if (hs) begin
      cand[m.out] = 1'b0;
      n.last = m.out;
    end
    for (int i = 0; i < 8; i++)
      if (rise[i] && cand[i]) n.ovf = 1;
    n.pend = cand | rise;
    if (!m.valid || hs) begin
      pick = -1;
      for (int k = 0; k < 8; k++) begin
        idx = (rr != 0) ? ((n.last + 1 + k) % 8) : k;
        if (pick < 0 && cand[idx]) pick = idx;
      end
      if (pick >= 0) begin
        n.valid = 1; n.out = pick;
      end else begin
        n.valid = 0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_models();
    chk("fix.valid",    32'(valid0), 32'(m0.valid));
    if (m0.valid) chk("fix.out", 32'(out0), 32'(m0.out));
    chk("fix.pending",  32'(pend0),  32'(m0.pend));
    chk("fix.overflow", 32'(ovf0),   32'(m0.ovf));
    chk("rr.valid",     32'(valid1), 32'(m1.valid));
    if (m1.valid) chk("rr.out", 32'(out1), 32'(m1.out));
    chk("rr.pending",   32'(pend1),  32'(m1.pend));
    chk("rr.overflow",  32'(ovf1),   32'(m1.ovf));
  endtask

  task automatic cycle();
    @(posedge clk);
    m0 = step(m0, 0, in_r, clr_r, rdy_r);
    m1 = step(m1, 1, in_r, clr_r, rdy_r);
    #1;
    compare_models();
  endtask

  task automatic do_reset(input logic [7:0] in_during);
    rst_n = 1'b0;
    in_r  = in_during;
    clr_r = 1'b0;
    rdy_r = 1'b0;
    m0 = model_reset();
    m1 = model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] in_v;
    bit         clr_v;
    bit         rdy_v;
    bit         e_valid;
    int         e_out;
    logic [7:0] e_pend;
    bit         e_ovf;
  } vec_t;

  vec_t vecs[23];

  initial begin
    // Fixed-priority expectations, one row per clock edge.
    vecs[0]  = '{8'h10, 0, 1, 0, 0, 8'h10, 0};
    vecs[1]  = '{8'h00, 0, 1, 1, 4, 8'h10, 0};
    vecs[2]  = '{8'h00, 0, 1, 0, 4, 8'h00, 0};
    vecs[3]  = '{8'h85, 0, 1, 0, 4, 8'h85, 0};
    vecs[4]  = '{8'h85, 0, 1, 1, 0, 8'h85, 0};
    vecs[5]  = '{8'h85, 0, 1, 1, 2, 8'h84, 0};
    vecs[6]  = '{8'h00, 0, 1, 1, 7, 8'h80, 0};
    vecs[7]  = '{8'h00, 0, 1, 0, 7, 8'h00, 0};
    vecs[8]  = '{8'h08, 0, 0, 0, 7, 8'h08, 0};
    vecs[9]  = '{8'h08, 0, 0, 1, 3, 8'h08, 0};
    vecs[10] = '{8'h09, 0, 0, 1, 3, 8'h09, 0};
    vecs[11] = '{8'h09, 0, 0, 1, 3, 8'h09, 0};
    vecs[12] = '{8'h09, 0, 1, 1, 0, 8'h01, 0};
    vecs[13] = '{8'h00, 0, 0, 1, 0, 8'h01, 0};
    vecs[14] = '{8'h20, 0, 0, 1, 0, 8'h21, 0};
    vecs[15] = '{8'h00, 0, 0, 1, 0, 8'h21, 0};
    vecs[16] = '{8'h20, 0, 0, 1, 0, 8'h21, 1};
    vecs[17] = '{8'h00, 1, 0, 0, 0, 8'h00, 0};
    vecs[18] = '{8'h02, 0, 1, 0, 0, 8'h02, 0};
    vecs[19] = '{8'h00, 0, 0, 1, 1, 8'h02, 0};
    vecs[20] = '{8'h02, 0, 1, 0, 1, 8'h02, 0};
    vecs[21] = '{8'h00, 0, 1, 1, 1, 8'h02, 0};
    vecs[22] = '{8'h00, 0, 1, 0, 1, 8'h00, 0};

    do_reset(8'h00);
    chk("reset.valid",    32'(valid0), 32'(0));
    chk("reset.out",      32'(out0),   32'(0));
    chk("reset.pending",  32'(pend0),  32'(0));
    chk("reset.overflow", 32'(ovf0),   32'(0));

    for (int i = 0; i < 23; i++) begin
      in_r  = vecs[i].in_v;
      clr_r = vecs[i].clr_v;
      rdy_r = vecs[i].rdy_v;
      cycle();
      chk($sformatf("vec%0d.valid", i),   32'(valid0), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.out", i),     32'(out0),   32'(vecs[i].e_out));
      chk($sformatf("vec%0d.pending", i), 32'(pend0),  32'(vecs[i].e_pend));
      chk($sformatf("vec%0d.overflow", i), 32'(ovf0),  32'(vecs[i].e_ovf));
    end
    clr_r = 1'b0;

    // Round robin: serve index 2 first, then pending 0,1,2 comes out 0,1,2.
    do_reset(8'h00);
    in_r = 8'h04; rdy_r = 1'b1;
    cycle();
    in_r = 8'h00;
    cycle();
    chk("rr.first.valid", 32'(valid1), 32'(1));
    chk("rr.first.out",   32'(out1),   32'(2));
    cycle();
    chk("rr.idle.valid",  32'(valid1), 32'(0));
    in_r = 8'h07;
    cycle();
    chk("rr.load.pending", 32'(pend1), 32'(8'h07));
    in_r = 8'h00;
    cycle();
    chk("rr.seq0.out", 32'(out1), 32'(0));
    chk("rr.seq0.valid", 32'(valid1), 32'(1));
    cycle();
    chk("rr.seq1.out", 32'(out1), 32'(1));
    cycle();
    chk("rr.seq2.out", 32'(out1), 32'(2));
    cycle();
    chk("rr.done.valid", 32'(valid1), 32'(0));
    chk("rr.done.pending", 32'(pend1), 32'(0));

    // Randomized traffic against the model.
    do_reset(8'h00);
    for (int i = 0; i < 2000; i++) begin
      in_r  = in_r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      clr_r = ($urandom_range(0, 60) == 0);
      rdy_r = (i < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle();
    end
    clr_r = 1'b0;

    // Asynchronous reset in the middle of an offer.
    do_reset(8'h00);
    in_r = 8'h18; rdy_r = 1'b0;
    cycle();
    in_r = 8'h00;
    cycle();
    chk("offer.before.valid", 32'(valid0), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.valid",   32'(valid0), 32'(0));
    chk("async.out",     32'(out0),   32'(0));
    chk("async.pending", 32'(pend0),  32'(0));
    chk("async.rr.valid", 32'(valid1), 32'(0));
    chk("async.rr.pending", 32'(pend1), 32'(0));

    // Input already high when reset releases counts as an event.
    do_reset(8'h40);
    cycle();
    chk("release.pending", 32'(pend0), 32'(8'h40));
    cycle();
    chk("release.out", 32'(out0), 32'(6));
    chk("release.valid", 32'(valid0), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/event_encoder.md
EVENT_ENCODER -- requirements
Module: event_encoder

Interface
REQ-001 Parameter: ROUND_ROBIN, default 0, 0 = fixed priority (lowest index wins), 1 = rotating priority starting after last served index.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset is asynchronous and active-low.
REQ-004 Port: in  input  8  event request lines; a 0->1 transition on bit i is one event for index i.
REQ-005 Port: clr  input  1  synchronous clear of pending events, offer and overflow.
REQ-006 Port: ready  input  1  consumer accepts the offered code when high with valid.
REQ-007 Port: out  output  3  binary index of the offered event; inverse of a one-hot 3-to-8 decode.
REQ-008 Port: valid  output  1  out holds an un-served event.
REQ-009 Port: pending  output  8  registered pending-event bit vector.
REQ-010 Port: overflow  output  1  sticky flag: an event arrived for an index already pending.

Function
REQ-011 Edge detect SHALL use registered in_q; rise = in & ~in_q, evaluated every cycle; in_q <= in every edge.
REQ-012 pending[i] SHALL set at the edge where rise[i]=1.
REQ-013 FSM SHALL have two states: EMPTY (valid=0) and OFFER (valid=1).
REQ-014 Load condition: state EMPTY, or OFFER with valid&&ready (handshake).
REQ-015 On load, candidate set SHALL be registered pending with the bit being served (if handshake) removed; new rises that same edge are excluded.
REQ-016 On load with non-empty candidate set: out <= selected index, state OFFER; with empty set: state EMPTY, out holds last value.
REQ-017 ROUND_ROBIN=0: selection SHALL be lowest set index.
REQ-018 ROUND_ROBIN=1: selection SHALL be first set index scanning last+1, last+2, ... modulo 8; last updates to out on each handshake; last resets to 7.
REQ-019 Latency: rise sampled at edge k -> pending set at edge k -> valid=1 with out after edge k+1 (if EMPTY).
REQ-020 Throughput: one code per cycle with ready held high and multiple pending bits.
REQ-021 While valid && !ready, out and valid SHALL stay stable; higher-priority arrivals do not preempt.
REQ-022 Handshake SHALL clear pending[out] at that edge.
REQ-023 Simultaneous handshake clear and rise on same index: set wins, pending bit stays 1, no overflow.
REQ-024 rise[i] while pending[i]=1 and not being cleared that edge: overflow <= 1; event merged, not counted twice.
REQ-025 overflow SHALL stay 1 until clr or reset.
REQ-026 clr=1: pending <= 0, state EMPTY, overflow <= 0; clr wins over simultaneous rises and handshake; in_q still updates.

Reset
REQ-027 rst_n low SHALL immediately force: out=0, valid=0 (EMPTY), pending=0, overflow=0, in_q=0, last=7.
REQ-028 Input bits already high at reset release SHALL register as events at the first edge (in_q=0).
REQ-029 Reset asserted mid-offer SHALL drop the offer and all pending events without a handshake.

Structure
REQ-030 Package event_encoder_pkg SHALL hold N_EV=8, IDX_W=3 and the state enum {EMPTY, OFFER}.
REQ-031 One combinational sub-module prio_sel (8-bit request, 3-bit start index -> 3-bit index, found flag) SHALL implement both selection modes (start=0 for fixed).
REQ-032 No other hierarchy; all registers in event_encoder.

Verification
REQ-033 Reset, then in=8'b0001_0000 one cycle, ready=1 -> valid=1, out=3'd4 two edges after rise; pending=0 after handshake.
REQ-034 ROUND_ROBIN=0, in 0->8'b1000_0101 in one cycle, ready=1 -> out sequence 0,2,7 on consecutive cycles, then valid=0.
REQ-035 ROUND_ROBIN=1, last served=2, pending=8'b0000_0111 -> next out=0, then 1, then 2.
REQ-036 ready=0 with out=3 offered, new rise on bit 0 -> out stays 3, valid stays 1, pending=8'b0000_1001.
REQ-037 Bit 5 pending, not offered, second rise on in[5] -> overflow=1, pending[5]=1; clr -> overflow=0, pending=0, valid=0.
REQ-038 rst_n low during OFFER -> valid=0, out=0, pending=0 immediately, no clock required.
